// File: rtl/step_ctrl.sv
// rtl/step_ctrl.sv - debug run/step controller driving the mips core clock-enable
module step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16,
  parameter int RESET_MODE      = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             change,
  input  logic             step,
  output logic             cpu_en,
  output logic             mode,
  output logic             step_busy,
  output logic [CNT_W-1:0] step_count
);

  // Counter must be able to hold DEBOUNCE_CYCLES itself.
  localparam int DW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    PULSE = 2'd2
  } state_t;

  // Index 0 carries change, index 1 carries step; both paths are identical.
  logic [1:0]    raw;
  logic [1:0]    s1, s2, filt, filt_d;
  logic [DW-1:0] cnt [2];
  logic          change_evt, step_evt;
  state_t        state_q, state_d;

  assign raw = {step, change};

  // Synchronise, debounce and delay each button; filt follows s2 only after
  // s2 has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      filt   <= '0;
      filt_d <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DW'(DEBOUNCE_CYCLES)) begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + DW'(1);
        end
      end
    end
  end

  assign change_evt = filt[0] & ~filt_d[0];
  assign step_evt   = filt[1] & ~filt_d[1];

  // State register; reset lands in RUN or HALT depending on RESET_MODE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= (RESET_MODE != 0) ? HALT : RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; change always wins over step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (change_evt) state_d = HALT;
      HALT: begin
        if (change_evt)    state_d = RUN;
        else if (step_evt) state_d = PULSE;
      end
      PULSE:   state_d = change_evt ? RUN : HALT;
      default: state_d = RUN;
    endcase
  end

  // Moore output decode from the state register.
  always_comb begin
    cpu_en    = 1'b0;
    mode      = 1'b0;
    step_busy = 1'b0;
    case (state_q)
      RUN:   cpu_en = 1'b1;
      HALT:  mode   = 1'b1;
      PULSE: begin
        cpu_en    = 1'b1;
        mode      = 1'b1;
        step_busy = 1'b1;
      end
      default: cpu_en = 1'b1;
    endcase
  end

  // Count steps on entry to PULSE so the new value is visible with cpu_en.
  always_ff @(posedge clock) begin
    if (reset) begin
      step_count <= '0;
    end else if (state_d == PULSE && state_q != PULSE) begin
      step_count <= step_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// tb/tb_step_ctrl.sv - self-checking bench for step_ctrl
module tb_step_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        chg_a, stp_a, chg_b, stp_b;
  logic        cpu_en_a, mode_a, busy_a;
  logic        cpu_en_b, mode_b, busy_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        chg;
    logic        stp;
    int          hold;
    logic        e_mode;
    logic        e_cpu;
    int          e_pulses;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [8];
  vec_t sb_q [$];

  step_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(16), .RESET_MODE(0)) dut_a (
    .clock(clock), .reset(reset), .change(chg_a), .step(stp_a),
    .cpu_en(cpu_en_a), .mode(mode_a), .step_busy(busy_a), .step_count(cnt_a)
  );

  step_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(2), .RESET_MODE(1)) dut_b (
    .clock(clock), .reset(reset), .change(chg_b), .step(stp_b),
    .cpu_en(cpu_en_b), .mode(mode_b), .step_busy(busy_b), .step_count(cnt_b)
  );

  always #5 clock = ~clock;

  // Hard stop in case a wait ever runs away.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hold the given buttons on dut_a for v.hold edges, then let everything settle.
  task automatic apply_a(input vec_t v, output int pulses, output int bad_en);
    pulses = 0;
    bad_en = 0;
    chg_a  = v.chg;
    stp_a  = v.stp;
    for (int i = 0; i < v.hold + 14; i++) begin
      @(negedge clock);
      if (busy_a) begin
        pulses++;
        if (!cpu_en_a) bad_en++;
      end
      if (i == v.hold - 1) begin
        chg_a = 1'b0;
        stp_a = 1'b0;
      end
    end
  endtask

  task automatic press_b;
    stp_b = 1'b1;
    repeat (10) @(negedge clock);
    stp_b = 1'b0;
    repeat (14) @(negedge clock);
  endtask

  initial begin
    int   pulses, bad_en, flips;
    logic found;
    vec_t e;

    vecs[0] = '{1'b1, 1'b0, 10, 1'b1, 1'b0, 0, 16'd0};
    vecs[1] = '{1'b0, 1'b1, 10, 1'b1, 1'b0, 1, 16'd1};
    vecs[2] = '{1'b0, 1'b1, 10, 1'b1, 1'b0, 1, 16'd2};
    vecs[3] = '{1'b0, 1'b1,  2, 1'b1, 1'b0, 0, 16'd2};
    vecs[4] = '{1'b1, 1'b0,  3, 1'b1, 1'b0, 0, 16'd2};
    vecs[5] = '{1'b1, 1'b1, 10, 1'b0, 1'b1, 0, 16'd2};
    vecs[6] = '{1'b0, 1'b1, 10, 1'b0, 1'b1, 0, 16'd2};
    vecs[7] = '{1'b1, 1'b0, 10, 1'b1, 1'b0, 0, 16'd2};

    reset = 1'b1;
    chg_a = 1'b0; stp_a = 1'b0; chg_b = 1'b0; stp_b = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_a_cpu_en", 32'(cpu_en_a), 1);
    chk("rst_a_mode",   32'(mode_a),   0);
    chk("rst_a_busy",   32'(busy_a),   0);
    chk("rst_a_count",  32'(cnt_a),    0);
    chk("rst_b_cpu_en", 32'(cpu_en_b), 0);
    chk("rst_b_mode",   32'(mode_b),   1);
    chk("rst_b_busy",   32'(busy_b),   0);
    chk("rst_b_count",  32'(cnt_b),    0);

    // Latency: change first sampled on edge 0, state flips on edge 7.
    chg_a = 1'b1;
    repeat (7) @(negedge clock);
    chk("lat_halt_edge6_mode", 32'(mode_a), 0);
    @(negedge clock);
    chk("lat_halt_edge7_mode",   32'(mode_a),   1);
    chk("lat_halt_edge7_cpu_en", 32'(cpu_en_a), 0);
    flips = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (mode_a !== 1'b1) flips++;
    end
    chk("held_no_toggle", 32'(flips), 0);
    chg_a = 1'b0;
    repeat (14) @(negedge clock);
    chg_a = 1'b1;
    repeat (7) @(negedge clock);
    chk("lat_run_edge6_mode", 32'(mode_a), 1);
    @(negedge clock);
    chk("lat_run_edge7_mode",   32'(mode_a),   0);
    chk("lat_run_edge7_cpu_en", 32'(cpu_en_a), 1);
    chg_a = 1'b0;
    repeat (14) @(negedge clock);

    // Table of button actions on dut_a, scored through the queue.
    for (int i = 0; i < 8; i++) begin
      sb_q.push_back(vecs[i]);
      apply_a(vecs[i], pulses, bad_en);
      e = sb_q.pop_front();
      chk($sformatf("vec%0d_mode", i),   32'(mode_a),   32'(e.e_mode));
      chk($sformatf("vec%0d_cpu_en", i), 32'(cpu_en_a), 32'(e.e_cpu));
      chk($sformatf("vec%0d_pulses", i), 32'(pulses),   32'(e.e_pulses));
      chk($sformatf("vec%0d_count", i),  32'(cnt_a),    32'(e.e_cnt));
      chk($sformatf("vec%0d_pulse_en", i), 32'(bad_en), 0);
    end

    // Two-bit counter wraps after four steps.
    for (int k = 1; k <= 4; k++) begin
      press_b;
      chk($sformatf("wrap_count%0d", k), 32'(cnt_b),  32'(k % 4));
      chk($sformatf("wrap_mode%0d", k),  32'(mode_b), 1);
    end

    // Reset on the PULSE cycle of dut_a; dut_b sees change held through reset.
    stp_a = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clock);
      if (busy_a) found = 1'b1;
    end
    chk("pulse_seen",  32'(found), 1);
    chk("pulse_count", 32'(cnt_a), 3);
    reset = 1'b1;
    stp_a = 1'b0;
    chg_b = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midpulse_rst_mode",   32'(mode_a),   0);
    chk("midpulse_rst_cpu_en", 32'(cpu_en_a), 1);
    chk("midpulse_rst_busy",   32'(busy_a),   0);
    chk("midpulse_rst_count",  32'(cnt_a),    0);
    chk("held_rst_b_mode",     32'(mode_b),   1);
    chk("held_rst_b_count",    32'(cnt_b),    0);
    repeat (7) @(negedge clock);
    chk("held_rst_b_edge6_mode", 32'(mode_b), 1);
    @(negedge clock);
    chk("held_rst_b_edge7_mode",   32'(mode_b),   0);
    chk("held_rst_b_edge7_cpu_en", 32'(cpu_en_b), 1);
    chg_b = 1'b0;
    repeat (5) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
